// File: rtl/jpeg_enc_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_enc_pkg
//   Shared types and constants for the encoder's RGB -> JFIF YCbCr path.
//   - pix8_t  : 8-bit unsigned pixel component
//   - prod_t  : 26-bit signed product (8b unsigned x 17b signed coefficient)
//   - acc_t   : 28-bit signed per-channel accumulator
//   - ycc_t   : packed {y, cb, cr} output triple
//   Coefficients are Q16 (value * 65536), rows Y/Cb/Cr, columns R/G/B.
// ---------------------------------------------------------------------------
package jpeg_enc_pkg;

  typedef logic [7:0]         pix8_t;
  typedef logic signed [16:0] coef_t;
  typedef logic signed [25:0] prod_t;
  typedef logic signed [27:0] acc_t;

  typedef struct packed {
    pix8_t y;
    pix8_t cb;
    pix8_t cr;
  } ycc_t;

  localparam coef_t Y_R  =  17'sd19595;
  localparam coef_t Y_G  =  17'sd38470;
  localparam coef_t Y_B  =  17'sd7471;
  localparam coef_t CB_R = -17'sd11059;
  localparam coef_t CB_G = -17'sd21709;
  localparam coef_t CB_B =  17'sd32768;
  localparam coef_t CR_R =  17'sd32768;
  localparam coef_t CR_G = -17'sd27439;
  localparam coef_t CR_B = -17'sd5329;

  localparam acc_t ROUND_C    = 28'sd32768;     // 0.5 in Q16: round half up
  localparam acc_t CHROMA_OFS = 28'sd8388608;   // 128 << 16

  // Channel index: 0 = Y, 1 = Cb, 2 = Cr. Component index: 0 = R, 1 = G, 2 = B.
  function automatic coef_t coef(input int ch, input int comp);
    coef_t c;
    c = '0;
    case (ch)
      0: c = (comp == 0) ? Y_R  : (comp == 1) ? Y_G  : Y_B;
      1: c = (comp == 0) ? CB_R : (comp == 1) ? CB_G : CB_B;
      default: c = (comp == 0) ? CR_R : (comp == 1) ? CR_G : CR_B;
    endcase
    return c;
  endfunction

  // Constant added to each channel sum before the >>16.
  function automatic acc_t chan_ofs(input int ch);
    return (ch == 0) ? ROUND_C : (ROUND_C + CHROMA_OFS);
  endfunction

endpackage

// File: rtl/rgb_ycc_conv_pipe_if.sv
// ---------------------------------------------------------------------------
// rgb_ycc_conv_pipe_if
//   Stream bundle for the RGB -> YCbCr converter.
//   Input side : in_valid, in_ready, in_r, in_g, in_b
//   Output side: out_valid, out_ready, out_y, out_cb, out_cr
//   Status     : pix_cnt (CNT_W bits, pixels delivered)
//   slave  = converter view, master = source/sink (test or upstream) view.
// ---------------------------------------------------------------------------
interface rgb_ycc_conv_pipe_if
  import jpeg_enc_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic             in_valid;
  logic             in_ready;
  pix8_t            in_r;
  pix8_t            in_g;
  pix8_t            in_b;
  logic             out_valid;
  logic             out_ready;
  pix8_t            out_y;
  pix8_t            out_cb;
  pix8_t            out_cr;
  logic [CNT_W-1:0] pix_cnt;

  modport slave (
    input  in_valid, in_r, in_g, in_b, out_ready,
    output in_ready, out_valid, out_y, out_cb, out_cr, pix_cnt
  );

  modport master (
    output in_valid, in_r, in_g, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_cb, out_cr, pix_cnt
  );

endinterface

// File: rtl/rgb_ycc_conv_pipe_sat_round.sv
// ---------------------------------------------------------------------------
// ycc_sat_round
//   Takes one Q16 channel sum (rounding constant already added), drops the
//   fraction with an arithmetic >>16 and saturates to 0..255. With
//   LVL_SHIFT=1 the result is re-centred to two's complement (value-128),
//   which for an 8-bit value is just an inversion of bit 7.
//   acc_i : acc_t  Q16 channel sum
//   pix_o : pix8_t saturated (optionally level-shifted) component
// ---------------------------------------------------------------------------
module ycc_sat_round
  import jpeg_enc_pkg::*;
#(
  parameter bit LVL_SHIFT = 1'b0
) (
  input  acc_t  acc_i,
  output pix8_t pix_o
);

  logic signed [11:0] int_part;
  pix8_t              sat;
  logic               unused_frac;

  // Upper 12 bits are exactly acc_i >>> 16 (floor, sign preserved).
  assign int_part    = acc_i[27:16];
  assign unused_frac = ^acc_i[15:0];

  always_comb begin
    sat = int_part[7:0];
    if (int_part[11]) begin
      sat = 8'd0;
    end else if (|int_part[10:8]) begin
      sat = 8'd255;
    end
  end

  assign pix_o = sat ^ {LVL_SHIFT, 7'b0};

endmodule

// File: rtl/rgb_ycc_conv_pipe.sv
// ---------------------------------------------------------------------------
// rgb_ycc_conv_pipe
//   3-stage RGB -> JFIF YCbCr converter with valid/ready on both sides.
//     S1: nine registered products (component x Q16 coefficient)
//     S2: per-channel sums plus rounding / chroma offset
//     S3: >>16, saturate (optional level shift), registered to out_*
//   All stages move together when adv = !out_valid || out_ready, so a full
//   pipe keeps streaming one pixel per cycle and stalls as a unit.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : rgb_ycc_conv_pipe_if.slave stream bundle (see interface)
// ---------------------------------------------------------------------------
module rgb_ycc_conv_pipe
  import jpeg_enc_pkg::*;
#(
  parameter bit LVL_SHIFT = 1'b0,
  parameter int CNT_W     = 32
) (
  input logic                clk,
  input logic                rst,
  rgb_ycc_conv_pipe_if.slave bus
);

  logic             adv;
  logic [2:0]       vld_q, vld_d;      // [0]=S1, [1]=S2, [2]=S3 (out_valid)
  pix8_t            pix_in [3];
  prod_t            prod_q [3][3];
  prod_t            prod_d [3][3];
  acc_t             acc_q  [3];
  acc_t             acc_d  [3];
  pix8_t            sat_pix [3];
  ycc_t             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign adv          = !vld_q[2] || bus.out_ready;
  assign bus.in_ready = adv;

  assign pix_in[0] = bus.in_r;
  assign pix_in[1] = bus.in_g;
  assign pix_in[2] = bus.in_b;

  // Bubbles shift in like pixels; a stalled pipe holds every stage.
  assign vld_d = {vld_q[1:0], bus.in_valid};

  // S1 products: zero-extend the unsigned component so the multiply is signed.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      for (int cp = 0; cp < 3; cp++) begin
        prod_d[ch][cp] = prod_t'($signed({1'b0, pix_in[cp]})) * prod_t'(coef(ch, cp));
      end
    end
  end

  // S2 sums: products sign-extend into the 28-bit accumulator.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      acc_d[ch] = acc_t'(prod_q[ch][0]) + acc_t'(prod_q[ch][1])
                + acc_t'(prod_q[ch][2]) + chan_ofs(ch);
    end
  end

  // S3: one rounding/saturation slice per channel.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sat
      ycc_sat_round #(
        .LVL_SHIFT (LVL_SHIFT)
      ) u_sat (
        .acc_i (acc_q[gi]),
        .pix_o (sat_pix[gi])
      );
    end
  endgenerate

  assign out_d = {sat_pix[0], sat_pix[1], sat_pix[2]};
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      prod_q <= '{default: '{default: '0}};
      acc_q  <= '{default: '0};
      out_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (adv) begin
        vld_q  <= vld_d;
        prod_q <= prod_d;
        acc_q  <= acc_d;
        out_q  <= out_d;
      end
      if (vld_q[2] && bus.out_ready) begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign bus.out_valid = vld_q[2];
  assign bus.out_y     = out_q.y;
  assign bus.out_cb    = out_q.cb;
  assign bus.out_cr    = out_q.cr;
  assign bus.pix_cnt   = cnt_q;

endmodule
